// File: rtl/rob_multi.sv
// rob_multi: circular reorder buffer with in-order commit.
// Entries are allocated at the tail and completed by write-back ports.
// The head retires as a register write, a store (waits for st_ready), or a
// branch/jalr that may redirect fetch and squash every younger entry.
// Optional feature macro: ROB_DUAL_COMMIT_EN (allows two register commits per cycle).
module rob_multi #(
  parameter int XLEN     = 32,
  parameter int ID_W     = 3,
  parameter int WB_PORTS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_in,
  input  logic                     alloc_valid,
  input  logic [1:0]               alloc_kind,
  input  logic [4:0]               alloc_rd,
  input  logic                     alloc_pred,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic [XLEN-1:0]          alloc_imm,
  input  logic                     alloc_imm_rdy,
  output logic [ID_W-1:0]          alloc_id,
  output logic                     full,
  output logic                     empty,
  output logic [ID_W:0]            count,
  input  logic [WB_PORTS-1:0]      wb_valid,
  input  logic [WB_PORTS*ID_W-1:0] wb_id,
  input  logic [WB_PORTS*XLEN-1:0] wb_val,
  input  logic [WB_PORTS*XLEN-1:0] wb_addr,
  output logic [1:0]               cm_valid,
  output logic [9:0]               cm_rd,
  output logic [2*XLEN-1:0]        cm_val,
  output logic                     st_valid,
  output logic [XLEN-1:0]          st_addr,
  output logic [XLEN-1:0]          st_val,
  input  logic                     st_ready,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc
);

  localparam int DEPTH = 1 << ID_W;
  localparam logic [1:0] KIND_REG  = 2'd0;
  localparam logic [1:0] KIND_ST   = 2'd1;
  localparam logic [1:0] KIND_BR   = 2'd2;
  localparam logic [1:0] KIND_JALR = 2'd3;
  localparam logic [ID_W:0]   CNT_FULL = (ID_W+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(32'd4);

  // Pointers, occupancy and ready flags
  logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ID_W:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic [DEPTH-1:0] rdy_q, rdy_d;

  // Entry payload
  logic [1:0]       kind_q [DEPTH];
  logic [1:0]       kind_d [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [DEPTH-1:0] pred_q, pred_d;
  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  pc_d   [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [XLEN-1:0]  val_d  [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  addr_d [DEPTH];

  // Registered commit-side outputs
  logic [1:0]        cm_valid_q, cm_valid_d;
  logic [9:0]        cm_rd_q, cm_rd_d;
  logic [2*XLEN-1:0] cm_val_q, cm_val_d;
  logic              st_valid_q, st_valid_d;
  logic [XLEN-1:0]   st_addr_q, st_addr_d, st_val_q, st_val_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

  // Combinational helpers
  logic [WB_PORTS-1:0] wb_hit_s;
  logic [ID_W-1:0]     wb_idx_s [WB_PORTS];
  logic                head_ok_s;
  logic [1:0]          n_commit_s;
  logic                redir_s;
  logic                alloc_ok_s;
`ifdef ROB_DUAL_COMMIT_EN
  logic [ID_W-1:0]     next_id_s;
  logic                second_ok_s;
`endif

  assign alloc_id       = tail_q;
  assign count          = count_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign cm_valid       = cm_valid_q;
  assign cm_rd          = cm_rd_q;
  assign cm_val         = cm_val_q;
  assign st_valid       = st_valid_q;
  assign st_addr        = st_addr_q;
  assign st_val         = st_val_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

  // Write-back decode: a port only hits an id whose offset from head is below count
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_idx_s[p] = wb_id[p*ID_W +: ID_W];
      wb_hit_s[p] = wb_valid[p] && ({1'b0, ID_W'(wb_idx_s[p] - head_q)} < count_q);
    end
  end

  // Head eligibility, plus the second-oldest entry when dual commit is built in
  always_comb begin
    head_ok_s = (count_q != '0) && rdy_q[head_q];
`ifdef ROB_DUAL_COMMIT_EN
    next_id_s   = head_q + ID_W'(1'b1);
    second_ok_s = (count_q > (ID_W+1)'(1'b1)) && rdy_q[next_id_s] && (kind_q[next_id_s] == KIND_REG);
`endif
  end

  // Next-state: flush beats everything; otherwise commit, write-back, then alloc
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    rdy_d = rdy_q;
    kind_d = kind_q;
    rd_d = rd_q;
    pred_d = pred_q;
    pc_d = pc_q;
    val_d = val_q;
    addr_d = addr_q;
    cm_valid_d = 2'b00;
    cm_rd_d = 10'd0;
    cm_val_d = '0;
    st_valid_d = 1'b0;
    st_addr_d = '0;
    st_val_d = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d = '0;
    n_commit_s = 2'd0;
    redir_s = 1'b0;
    alloc_ok_s = 1'b0;
    if (flush_in) begin
      tail_d = head_q;
      count_d = '0;
    end else begin
      if (head_ok_s) begin
        case (kind_q[head_q])
          KIND_REG: begin
            cm_valid_d[0] = 1'b1;
            cm_rd_d[4:0] = rd_q[head_q];
            cm_val_d[XLEN-1:0] = val_q[head_q];
            n_commit_s = 2'd1;
`ifdef ROB_DUAL_COMMIT_EN
            if (second_ok_s) begin
              cm_valid_d[1] = 1'b1;
              cm_rd_d[9:5] = rd_q[next_id_s];
              cm_val_d[2*XLEN-1:XLEN] = val_q[next_id_s];
              n_commit_s = 2'd2;
            end else begin
              n_commit_s = 2'd1;
            end
`endif
          end
          KIND_ST: begin
            if (st_ready) begin
              st_valid_d = 1'b1;
              st_addr_d = addr_q[head_q];
              st_val_d = val_q[head_q];
              n_commit_s = 2'd1;
            end else begin
              n_commit_s = 2'd0;
            end
          end
          KIND_BR: begin
            n_commit_s = 2'd1;
            if (val_q[head_q][0] != pred_q[head_q]) begin
              redir_s = 1'b1;
              redirect_valid_d = 1'b1;
              redirect_pc_d = val_q[head_q][0] ? addr_q[head_q] : (pc_q[head_q] + PC_STEP);
            end else begin
              redir_s = 1'b0;
            end
          end
          KIND_JALR: begin
            n_commit_s = 2'd1;
            cm_valid_d[0] = 1'b1;
            cm_rd_d[4:0] = rd_q[head_q];
            cm_val_d[XLEN-1:0] = val_q[head_q];
            redir_s = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d = addr_q[head_q];
          end
          default: begin
            n_commit_s = 2'd0;
          end
        endcase
      end else begin
        n_commit_s = 2'd0;
      end

      // Later ports overwrite earlier ones, so the highest index wins on a shared id
      for (int p = 0; p < WB_PORTS; p++) begin
        rdy_d[wb_idx_s[p]]  = rdy_d[wb_idx_s[p]] | wb_hit_s[p];
        val_d[wb_idx_s[p]]  = (wb_hit_s[p] && (kind_q[wb_idx_s[p]] != KIND_JALR)) ?
                              wb_val[p*XLEN +: XLEN] : val_d[wb_idx_s[p]];
        addr_d[wb_idx_s[p]] = wb_hit_s[p] ? wb_addr[p*XLEN +: XLEN] : addr_d[wb_idx_s[p]];
      end

      // Fullness is judged on the count at cycle start; a redirect squashes the alloc too
      alloc_ok_s = alloc_valid && !full_q && !redir_s;
      kind_d[tail_q] = alloc_ok_s ? alloc_kind : kind_d[tail_q];
      rd_d[tail_q]   = alloc_ok_s ? alloc_rd : rd_d[tail_q];
      pred_d[tail_q] = alloc_ok_s ? alloc_pred : pred_d[tail_q];
      pc_d[tail_q]   = alloc_ok_s ? alloc_pc : pc_d[tail_q];
      addr_d[tail_q] = alloc_ok_s ? '0 : addr_d[tail_q];
      rdy_d[tail_q]  = alloc_ok_s ? ((alloc_kind == KIND_REG) && alloc_imm_rdy) : rdy_d[tail_q];
      val_d[tail_q]  = !alloc_ok_s ? val_d[tail_q] :
                       ((alloc_kind == KIND_REG) && alloc_imm_rdy) ? alloc_imm :
                       (alloc_kind == KIND_JALR) ? (alloc_pc + PC_STEP) : '0;

      head_d  = head_q + ID_W'(n_commit_s);
      tail_d  = redir_s ? (head_q + ID_W'(1'b1)) : (tail_q + ID_W'(alloc_ok_s));
      count_d = redir_s ? '0 : (count_q + (ID_W+1)'(alloc_ok_s) - (ID_W+1)'(n_commit_s));
    end
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  // Control state and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      rdy_q <= '0;
      cm_valid_q <= 2'b00;
      cm_rd_q <= 10'd0;
      cm_val_q <= '0;
      st_valid_q <= 1'b0;
      st_addr_q <= '0;
      st_val_q <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      rdy_q <= rdy_d;
      cm_valid_q <= cm_valid_d;
      cm_rd_q <= cm_rd_d;
      cm_val_q <= cm_val_d;
      st_valid_q <= st_valid_d;
      st_addr_q <= st_addr_d;
      st_val_q <= st_val_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Entry payload needs no reset: ready bits and the occupancy window gate every use
  always_ff @(posedge clk) begin
    kind_q <= kind_d;
    rd_q <= rd_d;
    pred_q <= pred_d;
    pc_q <= pc_d;
    val_q <= val_d;
    addr_q <= addr_d;
  end

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based model of the reorder buffer.
`timescale 1ns/1ps
module tb_rob_multi;
  localparam int XLEN = 32, ID_W = 3, WB_PORTS = 2, DEPTH = 8;

  logic clk = 1'b0;
  logic rst, flush_in, alloc_valid, alloc_pred, alloc_imm_rdy, st_ready;
  logic [1:0] alloc_kind;
  logic [4:0] alloc_rd;
  logic [XLEN-1:0] alloc_pc, alloc_imm;
  logic [ID_W-1:0] alloc_id;
  logic full, empty;
  logic [ID_W:0] count;
  logic [WB_PORTS-1:0] wb_valid;
  logic [WB_PORTS*ID_W-1:0] wb_id;
  logic [WB_PORTS*XLEN-1:0] wb_val, wb_addr;
  logic [1:0] cm_valid;
  logic [9:0] cm_rd;
  logic [2*XLEN-1:0] cm_val;
  logic st_valid, redirect_valid;
  logic [XLEN-1:0] st_addr, st_val, redirect_pc;

  always #5 clk = ~clk;

  rob_multi #(.XLEN(XLEN), .ID_W(ID_W), .WB_PORTS(WB_PORTS)) dut (
    .clk(clk), .rst(rst), .flush_in(flush_in),
    .alloc_valid(alloc_valid), .alloc_kind(alloc_kind), .alloc_rd(alloc_rd),
    .alloc_pred(alloc_pred), .alloc_pc(alloc_pc), .alloc_imm(alloc_imm),
    .alloc_imm_rdy(alloc_imm_rdy), .alloc_id(alloc_id), .full(full), .empty(empty),
    .count(count), .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val), .wb_addr(wb_addr),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_val(cm_val), .st_valid(st_valid),
    .st_addr(st_addr), .st_val(st_val), .st_ready(st_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] val;
    logic [31:0] addr;
    logic        ready;
  } ent_t;

  ent_t q[$];
  int unsigned m_head, m_tail;
  logic [1:0]  e_cm_valid;
  logic [9:0]  e_cm_rd;
  logic [63:0] e_cm_val;
  logic        e_st_valid, e_redir;
  logic [31:0] e_st_addr, e_st_val, e_rpc;
  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of in-flight entries, oldest first
  always @(posedge clk) begin : ref_model
    int sz, n, off;
    bit redir;
    ent_t e;
    logic [2:0] id;
    e_cm_valid = 2'b00; e_cm_rd = '0; e_cm_val = '0;
    e_st_valid = 1'b0; e_st_addr = '0; e_st_val = '0;
    e_redir = 1'b0; e_rpc = '0;
    if (rst) begin
      q.delete(); m_head = 0; m_tail = 0;
    end else if (flush_in) begin
      q.delete(); m_tail = m_head;
    end else begin
      sz = q.size(); n = 0; redir = 1'b0;
      if (sz > 0 && q[0].ready) begin
        case (q[0].kind)
          2'd0: begin
            e_cm_valid[0] = 1'b1; e_cm_rd[4:0] = q[0].rd; e_cm_val[31:0] = q[0].val; n = 1;
`ifdef ROB_DUAL_COMMIT_EN
            if (sz > 1 && q[1].ready && q[1].kind == 2'd0) begin
              e_cm_valid[1] = 1'b1; e_cm_rd[9:5] = q[1].rd; e_cm_val[63:32] = q[1].val; n = 2;
            end
`endif
          end
          2'd1: if (st_ready) begin
            e_st_valid = 1'b1; e_st_addr = q[0].addr; e_st_val = q[0].val; n = 1;
          end
          2'd2: begin
            n = 1;
            if (q[0].val[0] != q[0].pred) begin
              redir = 1'b1;
              e_rpc = q[0].val[0] ? q[0].addr : q[0].pc + 32'd4;
            end
          end
          default: begin
            n = 1; redir = 1'b1;
            e_cm_valid[0] = 1'b1; e_cm_rd[4:0] = q[0].rd; e_cm_val[31:0] = q[0].val;
            e_rpc = q[0].addr;
          end
        endcase
      end
      e_redir = redir;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p]) begin
          id = wb_id[p*ID_W +: ID_W];
          off = (int'(id) - int'(m_head) + DEPTH) % DEPTH;
          if (off < sz) begin
            e = q[off];
            e.ready = 1'b1;
            if (e.kind != 2'd3) e.val = wb_val[p*XLEN +: XLEN];
            e.addr = wb_addr[p*XLEN +: XLEN];
            q[off] = e;
          end
        end
      end
      repeat (n) void'(q.pop_front());
      m_head = (m_head + n) % DEPTH;
      if (redir) begin
        q.delete(); m_tail = m_head;
      end else if (alloc_valid && sz < DEPTH) begin
        e.kind = alloc_kind; e.rd = alloc_rd; e.pred = alloc_pred; e.pc = alloc_pc;
        e.addr = '0;
        e.ready = (alloc_kind == 2'd0) && alloc_imm_rdy;
        e.val = e.ready ? alloc_imm : (alloc_kind == 2'd3) ? alloc_pc + 32'd4 : 32'd0;
        q.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  // Compare every cycle on the falling edge, away from the register updates
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("alloc_id", 64'(alloc_id), 64'(m_tail));
      chk("cm_valid", 64'(cm_valid), 64'(e_cm_valid));
      if (e_cm_valid[0]) begin
        chk("cm_rd0", 64'(cm_rd[4:0]), 64'(e_cm_rd[4:0]));
        chk("cm_val0", 64'(cm_val[31:0]), 64'(e_cm_val[31:0]));
      end
      if (e_cm_valid[1]) begin
        chk("cm_rd1", 64'(cm_rd[9:5]), 64'(e_cm_rd[9:5]));
        chk("cm_val1", 64'(cm_val[63:32]), 64'(e_cm_val[63:32]));
      end
      chk("st_valid", 64'(st_valid), 64'(e_st_valid));
      if (e_st_valid) begin
        chk("st_addr", 64'(st_addr), 64'(e_st_addr));
        chk("st_val", 64'(st_val), 64'(e_st_val));
      end
      chk("redirect_valid", 64'(redirect_valid), 64'(e_redir));
      if (e_redir) chk("redirect_pc", 64'(redirect_pc), 64'(e_rpc));
    end
  end

  task automatic idle();
    rst = 1'b0; flush_in = 1'b0; alloc_valid = 1'b0; alloc_kind = 2'd0; alloc_rd = 5'd0;
    alloc_pred = 1'b0; alloc_pc = '0; alloc_imm = '0; alloc_imm_rdy = 1'b0;
    wb_valid = '0; wb_id = '0; wb_val = '0; wb_addr = '0; st_ready = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; cyc(); cyc(); idle();
  endtask

  task automatic set_alloc(input logic [1:0] k, input logic [4:0] rd, input logic pr,
                           input logic [31:0] pc, input logic [31:0] imm, input logic rdy);
    alloc_valid = 1'b1; alloc_kind = k; alloc_rd = rd; alloc_pred = pr;
    alloc_pc = pc; alloc_imm = imm; alloc_imm_rdy = rdy;
  endtask

  task automatic set_wb(input int p, input logic [2:0] id, input logic [31:0] v, input logic [31:0] a);
    wb_valid[p] = 1'b1; wb_id[p*ID_W +: ID_W] = id;
    wb_val[p*XLEN +: XLEN] = v; wb_addr[p*XLEN +: XLEN] = a;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [31:0] seen;
    idle(); rst = 1'b1; cyc(); chk_en = 1'b1; cyc(); idle();

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_cm_val", cm_val, 64'd0);

    // Fill all eight entries, ninth is dropped
    for (int i = 0; i < 8; i++) begin
      idle(); set_alloc(2'd0, 5'(i + 1), 1'b0, 32'h1000 + 32'(4 * i), 32'd0, 1'b0); cyc();
    end
    idle(); set_alloc(2'd0, 5'd20, 1'b0, 32'h2000, 32'd0, 1'b0); cyc();
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_alloc_id", 64'(alloc_id), 64'd0);

    // Two register entries become ready together
    do_reset();
    set_alloc(2'd0, 5'd5, 1'b0, 32'h0, 32'd0, 1'b0); cyc();
    idle(); set_alloc(2'd0, 5'd6, 1'b0, 32'h4, 32'd0, 1'b0); cyc();
    idle(); set_wb(0, 3'd0, 32'h55, 32'd0); set_wb(1, 3'd1, 32'h66, 32'd0); cyc();
    idle(); cyc();
`ifdef ROB_DUAL_COMMIT_EN
    chk("dual_cm_valid", 64'(cm_valid), 64'd3);
    chk("dual_cm_rd", 64'(cm_rd), 64'h0C5);
    chk("dual_cm_val", cm_val, 64'h0000_0066_0000_0055);
`else
    chk("single_cm_valid_a", 64'(cm_valid), 64'd1);
    chk("single_cm_rd_a", 64'(cm_rd[4:0]), 64'd5);
    chk("single_cm_val_a", 64'(cm_val[31:0]), 64'h55);
    idle(); cyc();
    chk("single_cm_valid_b", 64'(cm_valid), 64'd1);
    chk("single_cm_rd_b", 64'(cm_rd[4:0]), 64'd6);
    chk("single_cm_val_b", 64'(cm_val[31:0]), 64'h66);
`endif

    // Mispredicted branch squashes younger entries and a same-cycle alloc
    do_reset();
    set_alloc(2'd2, 5'd0, 1'b0, 32'h100, 32'd0, 1'b0); cyc();
    idle(); set_alloc(2'd0, 5'd1, 1'b0, 32'h104, 32'h77, 1'b1); cyc();
    idle(); set_alloc(2'd0, 5'd2, 1'b0, 32'h108, 32'h88, 1'b1); cyc();
    idle(); set_wb(0, 3'd0, 32'h1, 32'h140); cyc();
    idle(); set_alloc(2'd0, 5'd3, 1'b0, 32'h10C, 32'h99, 1'b1); cyc();
    chk("br_redirect_valid", 64'(redirect_valid), 64'd1);
    chk("br_redirect_pc", 64'(redirect_pc), 64'h140);
    chk("br_count", 64'(count), 64'd0);
    chk("br_alloc_id", 64'(alloc_id), 64'd1);
    for (int i = 0; i < 3; i++) begin
      idle(); cyc();
      chk("br_no_younger_commit", 64'(cm_valid), 64'd0);
    end

    // Store held off by st_ready for three cycles
    do_reset();
    set_alloc(2'd1, 5'd0, 1'b0, 32'h200, 32'd0, 1'b0); cyc();
    idle(); st_ready = 1'b0; set_wb(0, 3'd0, 32'hDEAD_BEEF, 32'h2000); cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); st_ready = 1'b0; cyc();
      chk("st_held", 64'(st_valid), 64'd0);
    end
    idle(); st_ready = 1'b1; cyc();
    chk("st_pulse", 64'(st_valid), 64'd1);
    chk("st_addr_lit", 64'(st_addr), 64'h2000);
    chk("st_val_lit", 64'(st_val), 64'hDEAD_BEEF);
    idle(); cyc();
    chk("st_one_pulse", 64'(st_valid), 64'd0);

    // Both ports write id 2; the higher port must win
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); set_alloc(2'd0, 5'(i + 1), 1'b0, 32'(4 * i), 32'd0, 1'b0); cyc();
    end
    idle(); set_wb(0, 3'd2, 32'h11, 32'd0); set_wb(1, 3'd2, 32'h22, 32'd0); cyc();
    idle(); set_wb(0, 3'd0, 32'h1, 32'd0); set_wb(1, 3'd1, 32'h2, 32'd0); cyc();
    found = 1'b0; seen = '0;
    for (int i = 0; i < 8; i++) begin
      idle(); cyc();
      if (cm_valid[0] && cm_rd[4:0] == 5'd3) begin found = 1'b1; seen = cm_val[31:0]; end
      if (cm_valid[1] && cm_rd[9:5] == 5'd3) begin found = 1'b1; seen = cm_val[63:32]; end
    end
    chk("wb_prio_seen", 64'(found), 64'd1);
    chk("wb_prio_val", 64'(seen), 64'h22);

    // Flush beats a ready head, an alloc and a write-back
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); set_alloc(2'd0, 5'(i + 8), 1'b0, 32'(4 * i), 32'd0, 1'b0); cyc();
    end
    idle(); set_wb(0, 3'd0, 32'h5, 32'd0); cyc();
    idle(); flush_in = 1'b1; set_alloc(2'd0, 5'd30, 1'b0, 32'h0, 32'h1, 1'b1);
    set_wb(1, 3'd1, 32'h6, 32'd0); cyc();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_cm_valid", 64'(cm_valid), 64'd0);
    chk("flush_st_valid", 64'(st_valid), 64'd0);
    chk("flush_redirect", 64'(redirect_valid), 64'd0);
    chk("flush_alloc_id", 64'(alloc_id), 64'd0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      idle();
      if ($urandom_range(299) == 0) rst = 1'b1;
      else if ($urandom_range(99) == 0) flush_in = 1'b1;
      if ($urandom_range(9) < 6)
        set_alloc(2'($urandom_range(3)), 5'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
                  $urandom, 1'($urandom));
      for (int p = 0; p < WB_PORTS; p++) begin
        if ($urandom_range(9) < 4) begin
          if (q.size() > 0 && $urandom_range(9) < 8)
            set_wb(p, 3'((m_head + $urandom_range(q.size() - 1)) % DEPTH), $urandom,
                   $urandom & 32'hFFFF_FFFC);
          else
            set_wb(p, 3'($urandom), $urandom, $urandom & 32'hFFFF_FFFC);
        end
      end
      st_ready = ($urandom_range(9) < 7);
      cyc();
    end

    idle(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
